uc_cmd_tx: RTL

UC_CMD_TX -- requirements
Module: uc_cmd_tx

---
 rtl/uc_cmd_pkg.sv | 50 +++++
 rtl/uc_cmd_tx_tick_gen.sv | 32 +++
 rtl/uc_cmd_tx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uc_cmd_pkg.sv
// Shared definitions for the ultrasonic command link (transmitter and receiver).
// Contents:
//   tx_state_t        frame sequencer states
//   DEF_TICK_DIV      clk cycles per line tick at 40 MHz (~576 Hz tick)
//   DEF_TICKS_PER_BIT line ticks per transmitted bit
//   DEF_GUARD_BITS    low bit-periods after each frame
//   CMD_MAX           highest legal command index
//   cmd_to_word()     command index -> 12-bit pair-coded word
//   word_to_cmd()     12-bit pair-coded word -> command index (receiver side)
package uc_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_GUARD    = 2'd3
  } tx_state_t;

  localparam int DEF_TICK_DIV      = 69445;
  localparam int DEF_TICKS_PER_BIT = 16;
  localparam int DEF_GUARD_BITS    = 16;
  localparam int CMD_MAX           = 24;

  // Value 13 is skipped in the 6-bit code so the STOP/SWEEP/LOCK words keep
  // their assigned patterns. Each value bit becomes a pair: 0 -> "01",
  // 1 -> "10", with the value MSB landing in W[11:10].
  function automatic logic [11:0] cmd_to_word(input logic [4:0] cmd);
    logic [5:0]  v;
    logic [11:0] w;
    v = (cmd <= 5'd12) ? {1'b0, cmd} : ({1'b0, cmd} + 6'd1);
    w = '0;
    for (int j = 0; j < 6; j++) begin
      w[2*j +: 2] = v[j] ? 2'b10 : 2'b01;
    end
    return w;
  endfunction

  // Inverse mapping; the left bit of each pair carries the value bit.
  function automatic logic [4:0] word_to_cmd(input logic [11:0] w);
    logic [5:0] v;
    logic [5:0] c;
    v = '0;
    for (int j = 0; j < 6; j++) begin
      v[j] = w[2*j+1];
    end
    c = (v <= 6'd12) ? v : (v - 6'd1);
    return c[4:0];
  endfunction

endpackage

// File: rtl/uc_cmd_tx_tick_gen.sv
// Free-running line-tick generator.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   restart  clears the divider so the next tick is a full TICK_DIV away
//   tick     one-cycle strobe while the divider sits at TICK_DIV-1
module uc_tick_gen #(
  parameter int TICK_DIV = 69445
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uc_cmd_tx.sv
// Ultrasonic command transmitter: accepts a command index, serialises a
// preamble bit, the 12-bit pair-coded word LSB first, then a low guard gap.
// Ports:
//   clk        system clock (40 MHz)
//   rst        asynchronous active-high reset, aborts any frame
//   cmd        command index 0..24
//   cmd_valid  command offered this cycle
//   cmd_ready  high while idle
//   cmd_err    one-cycle pulse when an out-of-range command is offered
//   tx_out     registered serial line, idle low
//   busy       high from accept until the guard period ends
//   tick_out   line-tick strobe for debug
module uc_cmd_tx
  import uc_cmd_pkg::*;
#(
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT,
  parameter int GUARD_BITS    = DEF_GUARD_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       cmd_err,
  output logic       tx_out,
  output logic       busy,
  output logic       tick_out
);

  localparam int TW = $clog2(TICKS_PER_BIT + 1);
  localparam int IW = $clog2(((GUARD_BITS > 12) ? GUARD_BITS : 12) + 1);

  tx_state_t     state;
  logic [TW-1:0] btick;
  logic [IW-1:0] idx;
  logic [11:0]   shreg;
  logic          tick;
  logic          accept;
  logic          bit_end;

  assign accept  = cmd_valid && cmd_ready && (cmd <= 5'(CMD_MAX));
  assign bit_end = tick && (btick == TW'(TICKS_PER_BIT - 1));
  assign tick_out = tick;

  // Restarting the divider on accept aligns every bit boundary to the accept
  // edge, so a bit period is exactly TICKS_PER_BIT*TICK_DIV cycles.
  uc_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx_out    <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      cmd_err   <= 1'b0;
      btick     <= '0;
      idx       <= '0;
    end else begin
      cmd_err <= 1'b0;
      if (state == ST_IDLE) begin
        if (cmd_valid) begin
          if (cmd > 5'(CMD_MAX)) begin
            cmd_err <= 1'b1;
          end else begin
            state     <= ST_PREAMBLE;
            tx_out    <= 1'b1;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            btick     <= '0;
            idx       <= '0;
          end
        end
      end else if (tick) begin
        if (!bit_end) begin
          btick <= btick + 1'b1;
        end else begin
          btick <= '0;
          unique case (state)
            ST_PREAMBLE: begin
              state  <= ST_DATA;
              tx_out <= shreg[0];
              idx    <= '0;
            end
            ST_DATA: begin
              if (idx == IW'(11)) begin
                state  <= ST_GUARD;
                tx_out <= 1'b0;
                idx    <= '0;
              end else begin
                tx_out <= shreg[0];
                idx    <= idx + 1'b1;
              end
            end
            ST_GUARD: begin
              if (idx == IW'(GUARD_BITS - 1)) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
                idx       <= '0;
              end else begin
                idx <= idx + 1'b1;
              end
            end
            default: begin
              state <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  // Word shifter: loaded at accept, consumed one bit per boundary. It only
  // feeds tx_out through the state machine, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= cmd_to_word(cmd);
    end else if (bit_end && (state == ST_PREAMBLE || state == ST_DATA)) begin
      shreg <= {1'b0, shreg[11:1]};
    end
  end

endmodule
